// File: rtl/rbm_sram_fifo_ctrl_if.sv
// Stream and SRAM-port bundle for rbm_sram_fifo_ctrl.
// slave is the controller's view; master is the environment (upstream, downstream, SRAM).
interface rbm_sram_fifo_ctrl_if #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
);
    logic          IN_VALID;
    logic [DW-1:0] IN_DATA;
    logic          IN_READY;
    logic          OUT_VALID;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_READY;
    logic [AW:0]   COUNT;
    logic          CE0;
    logic [AW-1:0] A0;
    logic [DW-1:0] D0;
    logic          WE0;
    logic [DW-1:0] WEM0;
    logic          CE1;
    logic [AW-1:0] A1;
    logic [DW-1:0] D1;
    logic          WE1;
    logic [DW-1:0] WEM1;
    logic [DW-1:0] Q1;

    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY, Q1,
        output IN_READY, OUT_VALID, OUT_DATA, COUNT,
        output CE0, A0, D0, WE0, WEM0,
        output CE1, A1, D1, WE1, WEM1
    );

    modport master (
        output IN_VALID, IN_DATA, OUT_READY, Q1,
        input  IN_READY, OUT_VALID, OUT_DATA, COUNT,
        input  CE0, A0, D0, WE0, WEM0,
        input  CE1, A1, D1, WE1, WEM1
    );
endinterface

// File: rtl/rbm_sram_fifo_ctrl.sv
// FIFO controller around a synchronous dual-port SRAM: port 0 writes, port 1 reads into
// a 2-entry registered output buffer so OUT_DATA/OUT_VALID come straight from flops.
module rbm_sram_fifo_ctrl #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic                CLK,
    input  logic                RST,
    rbm_sram_fifo_ctrl_if.slave bus
);
    localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_sram_cnt;
    logic [1:0]    r_ob_cnt;
    logic          r_inflight;
    logic          r_out_valid;
    logic [DW-1:0] r_ob_head;
    logic [DW-1:0] r_ob_tail;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_pop;
    logic          w_read;
    logic [2:0]    w_ob_demand;
    logic [1:0]    w_ob_cnt_d;
    logic [DW-1:0] w_ob_head_d;
    logic [DW-1:0] w_ob_tail_d;

    assign w_in_ready = !RST && (r_sram_cnt < Depth);
    assign w_accept   = bus.IN_VALID && w_in_ready;
    assign w_pop      = r_out_valid && bus.OUT_READY;

    // Buffer slots committed after this cycle: held words plus the one already on Q1.
    assign w_ob_demand = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_read      = !RST && (r_sram_cnt != '0) && (w_ob_demand < 3'd2);
    assign w_ob_cnt_d  = r_ob_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sram_cnt  <= '0;
            r_ob_cnt    <= '0;
            r_inflight  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_sram_cnt  <= r_sram_cnt + {{AW{1'b0}}, w_accept} - {{AW{1'b0}}, w_read};
            r_ob_cnt    <= w_ob_cnt_d;
            r_inflight  <= w_read;
            r_out_valid <= (w_ob_cnt_d != 2'd0);
        end
    end

    // Head is the oldest word; a capture lands in whichever slot is the tail after any pop.
    always_comb begin
        w_ob_head_d = r_ob_head;
        w_ob_tail_d = r_ob_tail;
        unique case ({w_pop, r_inflight})
            2'b11: begin
                if (r_ob_cnt == 2'd2) begin
                    w_ob_head_d = r_ob_tail;
                    w_ob_tail_d = bus.Q1;
                end else begin
                    w_ob_head_d = bus.Q1;
                end
            end
            2'b10: w_ob_head_d = r_ob_tail;
            2'b01: begin
                if (r_ob_cnt == 2'd0) begin
                    w_ob_head_d = bus.Q1;
                end else begin
                    w_ob_tail_d = bus.Q1;
                end
            end
            2'b00: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        r_ob_head <= w_ob_head_d;
        r_ob_tail <= w_ob_tail_d;
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.OUT_DATA  = r_ob_head;
    assign bus.COUNT     = r_sram_cnt + {{AW{1'b0}}, r_inflight} + {{(AW-1){1'b0}}, r_ob_cnt};

    assign bus.CE0  = w_accept;
    assign bus.WE0  = w_accept;
    assign bus.A0   = r_wr_ptr;
    assign bus.D0   = bus.IN_DATA;
    assign bus.WEM0 = {DW{w_accept}};

    assign bus.CE1  = w_read;
    assign bus.A1   = r_rd_ptr;
    assign bus.D1   = '0;
    assign bus.WE1  = 1'b0;
    assign bus.WEM1 = '0;
endmodule

// File: tb/tb_rbm_sram_fifo_ctrl.sv
// Directed bench for rbm_sram_fifo_ctrl with a behavioural SRAM and an in-order scoreboard.
module tb_rbm_sram_fifo_ctrl;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rbm_sram_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    rbm_sram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Synchronous SRAM: nonblocking update gives old data on same-address read/write.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.CE0 && bus.WE0) begin
            mem[bus.A0] <= (mem[bus.A0] & ~bus.WEM0) | (bus.D0 & bus.WEM0);
        end
        if (bus.CE1) begin
            bus.Q1 <= mem[bus.A1];
        end
    end

    int            n_pass = 0;
    int            n_total = 0;
    int            n_acc = 0;
    int            n_pop = 0;
    int            ncyc;
    logic [DW-1:0] sb [$];
    bit            stab_en = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: score handshakes at the falling edge, then return just after the rising edge.
    task automatic cycle();
        logic [DW-1:0] exp_w;
        @(negedge clk);
        if (stab_en && prev_stall) begin
            check("stall_valid", 64'(bus.OUT_VALID), 64'd1);
            check("stall_data", 64'(bus.OUT_DATA), 64'(prev_data));
        end
        if (bus.OUT_VALID && bus.OUT_READY) begin
            n_pop++;
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("pop_data", 64'(bus.OUT_DATA), 64'(exp_w));
            end else begin
                check("pop_when_empty", 64'(bus.OUT_VALID), 64'd0);
            end
        end
        if (bus.IN_VALID && bus.IN_READY) begin
            sb.push_back(bus.IN_DATA);
            n_acc++;
        end
        prev_stall = bus.OUT_VALID && !bus.OUT_READY;
        prev_data  = bus.OUT_DATA;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        while (sb.size() != 0 && n < 1500) begin
            cycle();
            n++;
        end
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        @(negedge clk);
        check({tag, "_count"}, 64'(bus.COUNT), 64'd0);
        check({tag, "_valid"}, 64'(bus.OUT_VALID), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.IN_DATA   = 32'hDEAD_BEEF;
        bus.OUT_READY = 1'b0;

        // Reset gating and cleared state
        @(negedge clk);
        check("rst_in_ready", 64'(bus.IN_READY), 64'd0);
        check("rst_ce0", 64'(bus.CE0), 64'd0);
        check("rst_we0", 64'(bus.WE0), 64'd0);
        check("rst_ce1", 64'(bus.CE1), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
        check("rst_count", 64'(bus.COUNT), 64'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.IN_VALID = 1'b0;

        // Single word: accepted at t, visible at t+3
        bus.IN_VALID  = 1'b1;
        bus.IN_DATA   = 32'hA5A5_0001;
        bus.OUT_READY = 1'b1;
        @(negedge clk);
        check("lat_in_ready", 64'(bus.IN_READY), 64'd1);
        check("lat_ce0", 64'(bus.CE0), 64'd1);
        check("lat_we0", 64'(bus.WE0), 64'd1);
        check("lat_wem0", 64'(bus.WEM0), 64'hFFFF_FFFF);
        check("lat_a0", 64'(bus.A0), 64'd0);
        check("lat_d0", 64'(bus.D0), 64'hA5A5_0001);
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        @(negedge clk);
        check("lat_t1_valid", 64'(bus.OUT_VALID), 64'd0);
        check("lat_t1_ce1", 64'(bus.CE1), 64'd1);
        check("lat_t1_a1", 64'(bus.A1), 64'd0);
        check("lat_t1_we1", 64'(bus.WE1), 64'd0);
        check("lat_t1_count", 64'(bus.COUNT), 64'd1);
        check("lat_t1_ce0", 64'(bus.CE0), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_t2_valid", 64'(bus.OUT_VALID), 64'd0);
        check("lat_t2_count", 64'(bus.COUNT), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_t3_valid", 64'(bus.OUT_VALID), 64'd1);
        check("lat_t3_data", 64'(bus.OUT_DATA), 64'hA5A5_0001);
        check("lat_t3_count", 64'(bus.COUNT), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_t4_valid", 64'(bus.OUT_VALID), 64'd0);
        check("lat_t4_count", 64'(bus.COUNT), 64'd0);
        @(posedge clk);
        #1;

        // Streaming 2000 words: both pointers wrap, one word per cycle after fill
        n_acc = 0;
        n_pop = 0;
        ncyc  = 0;
        bus.OUT_READY = 1'b1;
        while (n_pop < 2000 && ncyc < 2200) begin
            bus.IN_VALID = (n_acc < 2000);
            bus.IN_DATA  = 32'h1000_0000 + 32'(n_acc);
            cycle();
            ncyc++;
        end
        check("stream_pops", 64'(n_pop), 64'd2000);
        check("stream_cycles", 64'(ncyc), 64'd2003);
        drain("stream");

        // Full: 1024 in SRAM plus 2 in the output buffer
        n_acc = 0;
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 1030; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = 32'h2000_0000 + 32'(i);
            cycle();
        end
        check("full_accepted", 64'(n_acc), 64'd1026);
        bus.IN_VALID = 1'b0;
        @(negedge clk);
        check("full_in_ready", 64'(bus.IN_READY), 64'd0);
        check("full_count", 64'(bus.COUNT), 64'd1026);
        check("full_valid", 64'(bus.OUT_VALID), 64'd1);
        @(posedge clk);
        #1;
        bus.OUT_READY = 1'b1;
        cycle();
        bus.OUT_READY = 1'b0;
        @(negedge clk);
        check("full_ready_after_pop", 64'(bus.IN_READY), 64'd1);
        check("full_count_after_pop", 64'(bus.COUNT), 64'd1025);
        @(posedge clk);
        #1;
        drain("full");

        // Random backpressure with stall-stability checks
        stab_en    = 1'b1;
        prev_stall = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bus.IN_VALID  = ($urandom_range(3) != 0);
            bus.IN_DATA   = $urandom;
            bus.OUT_READY = ($urandom_range(1) == 1);
            cycle();
        end
        drain("random");
        stab_en = 1'b0;

        // Reset while a read is in flight and the buffer holds a word
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = 32'h3000_0000 + 32'(i);
            cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_pre_count", 64'(bus.COUNT), 64'd3);
        check("mid_pre_valid", 64'(bus.OUT_VALID), 64'd1);
        check("mid_rst_in_ready", 64'(bus.IN_READY), 64'd0);
        check("mid_rst_ce0", 64'(bus.CE0), 64'd0);
        check("mid_rst_ce1", 64'(bus.CE1), 64'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.IN_VALID = 1'b0;
        sb.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        check("mid_post_valid", 64'(bus.OUT_VALID), 64'd0);
        check("mid_post_count", 64'(bus.COUNT), 64'd0);
        @(posedge clk);
        #1;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = 32'hBEEF_0000 + 32'(i);
            cycle();
        end
        n_pop = 0;
        drain("mid");
        check("mid_new_pops", 64'(n_pop), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
